// File: rtl/shift_arbiter.sv
// Purpose : two-requester round-robin arbiter feeding one shared parallel-in/serial-out shifter.
// Latency : a request sampled in IDLE at edge n gives ack + first (MSB) bit in cycle n+1, eos in n+BITS.
// Backpr. : requests are only sampled in IDLE; a requester holds req/d until its one-cycle ack.
// Ports   : clk, rst (sync, active-high); req0/d0/ack0 and req1/d1/ack1 request side;
//           ser_q/ser_vld/ser_src/eos serial side; busy = not IDLE.
module shift_arbiter #(
   parameter int BITS = 8,
   parameter int GAP  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0,
   input  logic [BITS-1:0] d0,
   output logic            ack0,
   input  logic            req1,
   input  logic [BITS-1:0] d1,
   output logic            ack1,
   output logic            ser_q,
   output logic            ser_vld,
   output logic            ser_src,
   output logic            eos,
   output logic            busy
);

   localparam int CW = $clog2(BITS);
   // Gap counter needs at least one bit even when GAP is 0 or 1.
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [BITS-1:0] r_shreg;
   logic [CW-1:0]   r_cnt;
   logic [GW-1:0]   r_gcnt;
   logic            r_last;
   logic            r_src;
   logic            r_ack0;
   logic            r_ack1;
   logic            w_gnt0;
   logic            w_gnt1;
   logic            w_last_bit;
   logic            w_gap_done;

   assign w_last_bit = (r_cnt == CW'(BITS - 1));
   assign w_gap_done = (r_gcnt == GW'(GAP - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      case (r_state)
         S_IDLE: begin
            // On a tie the requester that was not served last wins.
            if (req0 && req1) begin
               w_gnt0 = r_last;
               w_gnt1 = ~r_last;
            end else begin
               w_gnt0 = req0;
               w_gnt1 = req1;
            end
            if (w_gnt0 || w_gnt1) begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_last_bit) begin
               w_state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
            end
         end
         S_GAP: begin
            if (w_gap_done) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_gcnt  <= '0;
         r_last  <= 1'b1;
         r_src   <= 1'b0;
         r_ack0  <= 1'b0;
         r_ack1  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // Grants only happen in IDLE, so each ack is a single-cycle pulse.
         r_ack0  <= w_gnt0;
         r_ack1  <= w_gnt1;
         case (r_state)
            S_IDLE: begin
               if (w_gnt0 || w_gnt1) begin
                  r_shreg <= w_gnt1 ? d1 : d0;
                  r_cnt   <= '0;
                  r_src   <= w_gnt1;
                  r_last  <= w_gnt1;
               end
            end
            S_SHIFT: begin
               r_shreg <= {r_shreg[BITS-2:0], 1'b0};
               r_cnt   <= r_cnt + 1'b1;
               r_gcnt  <= '0;
            end
            S_GAP: begin
               r_gcnt <= r_gcnt + 1'b1;
            end
            default: begin
               r_gcnt <= '0;
            end
         endcase
      end
   end

   assign ack0    = r_ack0;
   assign ack1    = r_ack1;
   assign ser_vld = (r_state == S_SHIFT);
   assign ser_q   = (r_state == S_SHIFT) & r_shreg[BITS-1];
   assign ser_src = r_src;
   assign eos     = (r_state == S_SHIFT) & w_last_bit;
   assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: main instance BITS=8/GAP=1, second instance BITS=8/GAP=0.
// Expected words are queued as {src, word} when driven and compared when eos is seen.
module tb_shift_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [7:0] d0, d1;
   logic       ack0, ack1, ser_q, ser_vld, ser_src, eos, busy;

   logic       g_req0, g_req1;
   logic [7:0] g_d0, g_d1;
   logic       g_ack0, g_ack1, g_ser_q, g_ser_vld, g_ser_src, g_eos, g_busy;

   int checks   = 0;
   int failures = 0;

   logic [8:0] sb[$];
   logic [7:0] mon_word;
   int         mon_n;
   logic [8:0] mon_exp;

   always #5 clk = ~clk;

   shift_arbiter #(.BITS(8), .GAP(1)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0), .d0(d0), .ack0(ack0),
      .req1(req1), .d1(d1), .ack1(ack1),
      .ser_q(ser_q), .ser_vld(ser_vld), .ser_src(ser_src), .eos(eos), .busy(busy)
   );

   shift_arbiter #(.BITS(8), .GAP(0)) u_dut_g0 (
      .clk(clk), .rst(rst),
      .req0(g_req0), .d0(g_d0), .ack0(g_ack0),
      .req1(g_req1), .d1(g_d1), .ack1(g_ack1),
      .ser_q(g_ser_q), .ser_vld(g_ser_vld), .ser_src(g_ser_src), .eos(g_eos), .busy(g_busy)
   );

   // Serial monitor: rebuild each word and compare against the scoreboard on eos.
   always @(negedge clk) begin
      if (rst) begin
         mon_n    = 0;
         mon_word = '0;
      end else if (ser_vld) begin
         mon_word = {mon_word[6:0], ser_q};
         mon_n    = mon_n + 1;
         if (eos) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL word_unexpected got src=%0d word=%h, none queued", ser_src, mon_word);
            end else begin
               mon_exp = sb.pop_front();
               if ({ser_src, mon_word} !== mon_exp || mon_n != 8) begin
                  failures++;
                  $display("FAIL word_data got src=%0d word=%h bits=%0d exp src=%0d word=%h bits=8",
                           ser_src, mon_word, mon_n, mon_exp[8], mon_exp[7:0]);
               end
            end
            mon_n = 0;
         end
      end
   end

   task automatic do_reset;
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ack0, ack1, ser_q, ser_vld, ser_src, eos, busy} !== 7'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0000000",
                  {ack0, ack1, ser_q, ser_vld, ser_src, eos, busy});
      end
      rst = 1'b0;
   endtask

   task automatic test_single_word;
      logic [7:0] w;
      w    = 8'hA5;
      d0   = w;
      req0 = 1'b1;
      sb.push_back({1'b0, w});
      @(negedge clk);
      req0 = 1'b0;
      checks++;
      if ({ack0, ack1, ser_vld, busy, ser_src} !== 5'b10110) begin
         failures++;
         $display("FAIL single_grant got ack0,ack1,vld,busy,src=%b exp=10110",
                  {ack0, ack1, ser_vld, busy, ser_src});
      end
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if ({ser_vld, ser_q, eos, ack0} !== {1'b1, w[7-i], (i == 7), (i == 0)}) begin
            failures++;
            $display("FAIL single_bit%0d got vld,q,eos,ack0=%b exp=%b", i,
                     {ser_vld, ser_q, eos, ack0}, {1'b1, w[7-i], (i == 7), (i == 0)});
         end
      end
      @(negedge clk);
      checks++;
      if ({ser_vld, busy, eos} !== 3'b010) begin
         failures++;
         $display("FAIL single_gap got vld,busy,eos=%b exp=010", {ser_vld, busy, eos});
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL single_idle got busy=%b exp=0", busy);
      end
   endtask

   task automatic test_tie;
      int n;
      do_reset();
      d0   = 8'hFF;
      d1   = 8'h00;
      req0 = 1'b1;
      req1 = 1'b1;
      sb.push_back({1'b0, 8'hFF});
      sb.push_back({1'b1, 8'h00});
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(ack0 || ack1) && n < 20);
      checks++;
      if (!(ack0 === 1'b1 && ack1 === 1'b0 && ser_src === 1'b0)) begin
         failures++;
         $display("FAIL tie_first got ack0=%b ack1=%b src=%b exp 1 0 0", ack0, ack1, ser_src);
      end
      req0 = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack1 && n < 30);
      checks++;
      if (!(ack1 === 1'b1 && ser_src === 1'b1 && n == 10)) begin
         failures++;
         $display("FAIL tie_second got ack1=%b src=%b spacing=%0d exp 1 1 10", ack1, ser_src, n);
      end
      req1 = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_contention;
      int         n;
      logic       s;
      logic [7:0] v;
      do_reset();
      d0 = 8'($urandom_range(255));
      d1 = 8'($urandom_range(255));
      sb.push_back({1'b0, d0});
      sb.push_back({1'b1, d1});
      req0 = 1'b1;
      req1 = 1'b1;
      for (int w = 0; w < 6; w++) begin
         s = (w % 2) == 1;
         n = 0;
         do begin
            @(negedge clk);
            n++;
            checks++;
            if (ack0 && ack1) begin
               failures++;
               $display("FAIL contention_overlap got ack0=1 ack1=1 exp at most one");
            end
         end while (!(ack0 || ack1) && n < 40);
         checks++;
         if ({ack0, ack1, ser_src} !== {~s, s, s} || (w > 0 && n != 10)) begin
            failures++;
            $display("FAIL contention_word%0d got ack0,ack1,src=%b spacing=%0d exp=%b spacing=10",
                     w, {ack0, ack1, ser_src}, n, {~s, s, s});
         end
         v = 8'($urandom_range(255));
         if (!s) begin
            if (w + 2 < 6) begin
               d0 = v;
               sb.push_back({1'b0, v});
            end else begin
               req0 = 1'b0;
            end
         end else begin
            if (w + 2 < 6) begin
               d1 = v;
               sb.push_back({1'b1, v});
            end else begin
               req1 = 1'b0;
            end
         end
      end
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset_mid_word;
      int n;
      do_reset();
      d0   = 8'hC3;
      req0 = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack0 && n < 20);
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({ack0, ack1, ser_q, ser_vld, ser_src, eos, busy} !== 7'b0) begin
         failures++;
         $display("FAIL midreset_outputs got=%b exp=0000000",
                  {ack0, ack1, ser_q, ser_vld, ser_src, eos, busy});
      end
      @(negedge clk);
      rst  = 1'b0;
      d0   = 8'h3C;
      d1   = 8'h5A;
      req0 = 1'b1;
      req1 = 1'b1;
      sb.push_back({1'b0, 8'h3C});
      @(negedge clk);
      checks++;
      if ({ack0, ack1, ser_src} !== 3'b100) begin
         failures++;
         $display("FAIL midreset_tie got ack0,ack1,src=%b exp=100", {ack0, ack1, ser_src});
      end
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_req_while_busy;
      int n;
      do_reset();
      d0   = 8'h96;
      req0 = 1'b1;
      sb.push_back({1'b0, 8'h96});
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack0 && n < 20);
      req0 = 1'b0;
      @(negedge clk);
      d1   = 8'h77;
      req1 = 1'b1;
      repeat (2) @(negedge clk);
      req1 = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         checks++;
         if (ack1 !== 1'b0 || ser_src !== 1'b0) begin
            failures++;
            $display("FAIL busyreq_cycle%0d got ack1=%b src=%b exp 0 0", i, ack1, ser_src);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL busyreq_idle got busy=%b exp=0", busy);
      end
   endtask

   task automatic test_back_to_back_gap0;
      int n;
      int lows;
      g_d0   = 8'h81;
      g_req0 = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!g_ack0 && n < 20);
      checks++;
      if ({g_ack0, g_ser_vld, g_ser_q, g_ser_src} !== 4'b1110) begin
         failures++;
         $display("FAIL gap0_first got ack,vld,q,src=%b exp=1110",
                  {g_ack0, g_ser_vld, g_ser_q, g_ser_src});
      end
      n    = 0;
      lows = 0;
      do begin
         @(negedge clk);
         n++;
         if (!g_ser_vld) lows++;
      end while (!g_ack0 && n < 30);
      checks++;
      if (n != 9 || lows != 1) begin
         failures++;
         $display("FAIL gap0_period got period=%0d idle=%0d exp period=9 idle=1", n, lows);
      end
      g_req0 = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      rst    = 1'b1;
      req0   = 1'b0;
      req1   = 1'b0;
      d0     = '0;
      d1     = '0;
      g_req0 = 1'b0;
      g_req1 = 1'b0;
      g_d0   = '0;
      g_d1   = '0;
      mon_n  = 0;
      test_reset();
      test_single_word();
      test_tie();
      test_contention();
      test_reset_mid_word();
      test_req_while_busy();
      do_reset();
      test_back_to_back_gap0();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got %0d words pending exp 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no completion exp finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
